// File: rtl/life_cursor_ctrl.sv
// life_cursor_ctrl: debounced button cursor and phase-aligned cell flip strobe
// for the rotating life data store. The store shifts one position per cycle, so
// the flip strobe is issued only on the phase where physical bit {y,x} holds
// logical cell (x,y).
module life_cursor_ctrl #(
    parameter int unsigned X          = 8,
    parameter int unsigned Y          = 8,
    parameter int unsigned LOG2X      = 3,
    parameter int unsigned LOG2Y      = 3,
    parameter int unsigned DEBOUNCE   = 16,
    parameter int unsigned FLIP_PHASE = 0,
    localparam int unsigned N         = X * Y,
    localparam int unsigned PW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_flip,
    output logic [LOG2X-1:0] cursor_x,
    output logic [LOG2Y-1:0] cursor_y,
    output logic             cell_flip,
    output logic             flip_pending,
    output logic [PW-1:0]    phase
);

    localparam int unsigned CW = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0]    CNT_MAX   = CW'(DEBOUNCE - 1);
    localparam logic [PW-1:0]    PHASE_MAX = PW'(N - 1);
    // Phase one cycle before FLIP_PHASE, so the registered strobe lands on it.
    localparam logic [PW-1:0]    PRE_PHASE = PW'((FLIP_PHASE + N - 1) % N);
    localparam logic [LOG2X-1:0] X_MAX     = LOG2X'(X - 1);
    localparam logic [LOG2Y-1:0] Y_MAX     = LOG2Y'(Y - 1);

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 flip.
    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DOWN  = 1;
    localparam int unsigned B_LEFT  = 2;
    localparam int unsigned B_RIGHT = 3;
    localparam int unsigned B_FLIP  = 4;

    typedef enum logic [1:0] {StIdle, StPend, StFire} state_e;

    logic [4:0]    raw;
    logic [4:0]    sync1_q;
    logic [4:0]    sync2_q;
    logic [4:0]    deb_q;
    logic [CW-1:0] cnt_q [5];
    logic [4:0]    press;
    state_e        state_q;
    logic [LOG2X-1:0] x_d;
    logic [LOG2Y-1:0] y_d;

    assign raw = {btn_flip, btn_right, btn_left, btn_down, btn_up};

    // Free-running phase counter, lock-stepped with the store's rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (phase == PHASE_MAX) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Two-flop synchroniser plus stability counter per button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press event: the cycle in which the debounced level is about to rise.
    always_comb begin
        press = '0;
        for (int i = 0; i < 5; i++) begin
            press[i] = sync2_q[i] & ~deb_q[i] & (cnt_q[i] == CNT_MAX);
        end
    end

    // Next cursor position with explicit wrap; opposing presses cancel.
    always_comb begin
        x_d = cursor_x;
        y_d = cursor_y;
        unique case ({press[B_RIGHT], press[B_LEFT]})
            2'b10:   x_d = (cursor_x == X_MAX) ? '0 : cursor_x + 1'b1;
            2'b01:   x_d = (cursor_x == '0) ? X_MAX : cursor_x - 1'b1;
            default: x_d = cursor_x;
        endcase
        unique case ({press[B_DOWN], press[B_UP]})
            2'b10:   y_d = (cursor_y == Y_MAX) ? '0 : cursor_y + 1'b1;
            2'b01:   y_d = (cursor_y == '0) ? Y_MAX : cursor_y - 1'b1;
            default: y_d = cursor_y;
        endcase
    end

    // Cursor register; frozen while a flip is outstanding so moves are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (state_q == StIdle) begin
            cursor_x <= x_d;
            cursor_y <= y_d;
        end
    end

    // Flip FSM: latch the intent, wait for the aligned phase, strobe once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cell_flip    <= 1'b0;
            flip_pending <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cell_flip <= 1'b0;
                    if (press[B_FLIP]) begin
                        state_q      <= StPend;
                        flip_pending <= 1'b1;
                    end
                end
                StPend: begin
                    if (phase == PRE_PHASE) begin
                        state_q   <= StFire;
                        cell_flip <= 1'b1;
                    end
                end
                StFire: begin
                    state_q      <= StIdle;
                    cell_flip    <= 1'b0;
                    flip_pending <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    cell_flip    <= 1'b0;
                    flip_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
